// File: rtl/control_pkg.sv
// control_pkg: state encodings, opcode constants and datapath select codes for multicycle_control_v2
package control_pkg;
    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WRITE = 4'd4;
    localparam logic [3:0] S_LOAD_WB   = 4'd5;
    localparam logic [3:0] S_EXEC_R    = 4'd6;
    localparam logic [3:0] S_EXEC_I    = 4'd7;
    localparam logic [3:0] S_ALU_WB    = 4'd8;
    localparam logic [3:0] S_BRANCH    = 4'd9;
    localparam logic [3:0] S_JAL       = 4'd10;
    localparam logic [3:0] S_JALR      = 4'd11;
    localparam logic [3:0] S_EXEC_LUI  = 4'd12;
    localparam logic [3:0] S_TRAP      = 4'd13;
    localparam logic [3:0] S_FAULT     = 4'd14;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] M2R_ALU = 2'd0, M2R_MDR = 2'd1, M2R_PC = 2'd2;
    localparam logic [1:0] SA_PC = 2'd0, SA_RS1 = 2'd1, SA_OLD_PC = 2'd2, SA_ZERO = 2'd3;
    localparam logic [1:0] SB_RS2 = 2'd0, SB_FOUR = 2'd1, SB_IMM = 2'd2;
    localparam logic [1:0] ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_FUNCT = 2'd2;
    localparam logic [1:0] PC_ALU = 2'd0, PC_ALUOUT = 2'd1;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       mem_sel_data;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_to_reg;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       mem_fault;
        logic       illegal_instr;
    } ctrl_t;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: saturating count of memory wait cycles; expired flags the last allowed wait cycle
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TMR_W       = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);
    localparam logic [TMR_W-1:0] LAST = TMR_W'(MEM_TIMEOUT - 1);
    logic [TMR_W-1:0] cnt_q, cnt_d;
    // clear on state entry, otherwise count non-ready cycles up to saturation
    always_comb cnt_d = clear ? '0 : (en && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    // counter register
    always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
    assign expired = (MEM_TIMEOUT != 0) && en && cnt_q == LAST;
endmodule

// File: rtl/multicycle_control_v2.sv
// multicycle_control_v2: RV32I-subset multicycle control FSM; define ILLEGAL_TRAP_EN to trap undecodable opcodes
module multicycle_control_v2
    import control_pkg::*;
#(
    parameter int OPCODE_W    = 7,
    parameter int STATE_W     = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int TMR_W       = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                mem_sel_data,
    output logic                mem_read,
    output logic                mem_write,
    output logic [1:0]          mem_to_reg,
    output logic                ir_write,
    output logic                reg_write,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_src,
    output logic [STATE_W-1:0]  state_o,
    output logic                mem_fault,
    output logic                illegal_instr
);
`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    logic [STATE_W-1:0] state_q, state_d;
    logic               waiting, expired;
    ctrl_t              c;

    assign waiting = state_q == S_FETCH || state_q == S_MEM_READ || state_q == S_MEM_WRITE;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .TMR_W(TMR_W)) u_timer (
        .clk(clk),
        .rst(rst),
        .clear(state_d != state_q),
        .en(waiting && !mem_ready),
        .expired(expired)
    );

    // next state: ready completes a wait state even on the timeout cycle
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:     state_d = mem_ready ? S_DECODE : expired ? S_FAULT : S_FETCH;
            S_DECODE:
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_LUI:            state_d = S_EXEC_LUI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    default:           state_d = TRAP_EN ? S_TRAP : S_FETCH;
                endcase
            S_MEM_ADDR:  state_d = opcode == OP_LOAD ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_d = mem_ready ? S_LOAD_WB : expired ? S_FAULT : S_MEM_READ;
            S_MEM_WRITE: state_d = mem_ready ? S_FETCH : expired ? S_FAULT : S_MEM_WRITE;
            S_EXEC_R, S_EXEC_I, S_EXEC_LUI: state_d = S_ALU_WB;
            S_TRAP:      state_d = S_TRAP;
            S_FAULT:     state_d = S_FAULT;
            default:     state_d = S_FETCH;
        endcase
    end

    // state register
    always_ff @(posedge clk) state_q <= rst ? S_FETCH : state_d;

    // Moore strobe decode; FETCH loads IR and PC only in the ready cycle
    always_comb begin
        c = '0;
        case (state_q)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_a = SA_PC;
                c.alu_src_b = SB_FOUR;
                c.alu_op    = ALU_ADD;
                c.ir_write  = mem_ready;
                c.pc_write  = mem_ready;
            end
            S_DECODE: begin
                c.alu_src_a = SA_OLD_PC;
                c.alu_src_b = SB_IMM;
                c.alu_op    = ALU_ADD;
            end
            S_MEM_ADDR: begin
                c.alu_src_a = SA_RS1;
                c.alu_src_b = SB_IMM;
                c.alu_op    = ALU_ADD;
            end
            S_MEM_READ: begin
                c.mem_read     = 1'b1;
                c.mem_sel_data = 1'b1;
            end
            S_MEM_WRITE: begin
                c.mem_write    = 1'b1;
                c.mem_sel_data = 1'b1;
            end
            S_LOAD_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = M2R_MDR;
            end
            S_EXEC_R: begin
                c.alu_src_a = SA_RS1;
                c.alu_src_b = SB_RS2;
                c.alu_op    = ALU_FUNCT;
            end
            S_EXEC_I: begin
                c.alu_src_a = SA_RS1;
                c.alu_src_b = SB_IMM;
                c.alu_op    = ALU_FUNCT;
            end
            S_EXEC_LUI: begin
                c.alu_src_a = SA_ZERO;
                c.alu_src_b = SB_IMM;
                c.alu_op    = ALU_ADD;
            end
            S_ALU_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = M2R_ALU;
            end
            S_BRANCH: begin
                c.alu_src_a     = SA_RS1;
                c.alu_src_b     = SB_RS2;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_src        = PC_ALUOUT;
            end
            S_JAL: begin
                c.pc_write   = 1'b1;
                c.pc_src     = PC_ALUOUT;
                c.reg_write  = 1'b1;
                c.mem_to_reg = M2R_PC;
            end
            S_JALR: begin
                c.alu_src_a  = SA_RS1;
                c.alu_src_b  = SB_IMM;
                c.alu_op     = ALU_ADD;
                c.pc_write   = 1'b1;
                c.pc_src     = PC_ALU;
                c.reg_write  = 1'b1;
                c.mem_to_reg = M2R_PC;
            end
            S_TRAP:  c.illegal_instr = TRAP_EN;
            S_FAULT: c.mem_fault = 1'b1;
            default: c = '0;
        endcase
    end

    assign state_o = rst ? '0 : state_q;
    assign {pc_write, pc_write_cond, mem_sel_data, mem_read, mem_write, mem_to_reg, ir_write, reg_write,
            alu_src_a, alu_src_b, alu_op, pc_src, mem_fault, illegal_instr} = rst ? '0 : c;
endmodule

// File: tb/tb_multicycle_control_v2.sv
// tb_multicycle_control_v2: randomized scoreboard bench for the multicycle controller
module tb_multicycle_control_v2;
    localparam int TO = 15;
    localparam int FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_READ = 3, MEM_WRITE = 4, LOAD_WB = 5,
                   EXEC_R = 6, EXEC_I = 7, ALU_WB = 8, BRANCH = 9, JAL = 10, JALR = 11,
                   EXEC_LUI = 12, TRAP = 13, FAULT = 14;
    localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RR = 7'b0110011, II = 7'b0010011,
                           LU = 7'b0110111, BR = 7'b1100011, JA = 7'b1101111, JR = 7'b1100111;

    typedef struct packed {
        logic [3:0]  st;
        logic [18:0] o;
    } exp_t;

    logic        clk = 0, rst = 1, mem_ready = 0;
    logic [6:0]  opcode = 0;
    logic        pc_write, pc_write_cond, mem_sel_data, mem_read, mem_write, ir_write, reg_write;
    logic        mem_fault, illegal_instr;
    logic [1:0]  mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src;
    logic [3:0]  state_o;
    logic [18:0] act;
    exp_t        sb[$];
    exp_t        e;
    int          n_cmp = 0, n_bad = 0;

    multicycle_control_v2 #(.OPCODE_W(7), .STATE_W(4), .MEM_TIMEOUT(TO), .TMR_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .mem_sel_data(mem_sel_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg), .ir_write(ir_write),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_src(pc_src), .state_o(state_o), .mem_fault(mem_fault), .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    assign act = {pc_write, pc_write_cond, mem_sel_data, mem_read, mem_write, mem_to_reg, ir_write,
                  reg_write, alu_src_a, alu_src_b, alu_op, pc_src, mem_fault, illegal_instr};

    // strobe table straight from the phase descriptions
    function automatic logic [18:0] spec_out(input int s, input bit r);
        logic pw = 0, pwc = 0, sel = 0, mr = 0, mw = 0, irw = 0, rw = 0, mf = 0, il = 0;
        logic [1:0] m2r = 0, sa = 0, sbb = 0, op = 0, ps = 0;
        case (s)
            FETCH:     begin mr = 1; sbb = 1; pw = r; irw = r; end
            DECODE:    begin sa = 2; sbb = 2; end
            MEM_ADDR:  begin sa = 1; sbb = 2; end
            MEM_READ:  begin mr = 1; sel = 1; end
            MEM_WRITE: begin mw = 1; sel = 1; end
            LOAD_WB:   begin rw = 1; m2r = 1; end
            EXEC_R:    begin sa = 1; op = 2; end
            EXEC_I:    begin sa = 1; sbb = 2; op = 2; end
            EXEC_LUI:  begin sa = 3; sbb = 2; end
            ALU_WB:    rw = 1;
            BRANCH:    begin sa = 1; op = 1; pwc = 1; ps = 1; end
            JAL:       begin pw = 1; ps = 1; rw = 1; m2r = 2; end
            JALR:      begin sa = 1; sbb = 2; pw = 1; rw = 1; m2r = 2; end
            TRAP:      il = 1;
            FAULT:     mf = 1;
            default:   ;
        endcase
        return {pw, pwc, sel, mr, mw, m2r, irw, rw, sa, sbb, op, ps, mf, il};
    endfunction

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    // monitor: every cycle the DUT presents a Moore output; compare against the queued expectation
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if ({state_o, act} !== {e.st, e.o}) begin
                n_bad++;
                $display("FAIL cycle_outputs t=%0t: got state=%0d outs=%b, want state=%0d outs=%b",
                         $time, state_o, act, e.st, e.o);
            end
        end
    end

    task automatic cyc(input int s, input bit r);
        mem_ready = r;
        sb.push_back('{st: 4'(s), o: spec_out(s, r)});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        repeat (2) begin
            mem_ready = rb();
            sb.push_back('{st: 4'd0, o: 19'd0});
            @(posedge clk);
            #1;
        end
        rst = 0;
    endtask

    // a wait state: n non-ready cycles then ready; n >= TO means the timeout fires instead
    task automatic wait_phase(input int s, input int n, output bit f);
        f = n >= TO;
        for (int i = 0; i < (f ? TO : n); i++) cyc(s, 1'b0);
        if (!f) cyc(s, 1'b1);
    endtask

    task automatic fault_hold();
        repeat (4) cyc(FAULT, rb());
        do_reset();
    endtask

    // one instruction, expressed as its phase sequence
    task automatic run_instr(input logic [6:0] op, input int wf, input int wm);
        bit f;
        opcode = 7'($urandom);
        wait_phase(FETCH, wf, f);
        if (f) begin
            fault_hold();
            return;
        end
        opcode = op;
        cyc(DECODE, rb());
        case (op)
            LD: begin
                cyc(MEM_ADDR, rb());
                wait_phase(MEM_READ, wm, f);
                if (f) fault_hold();
                else cyc(LOAD_WB, rb());
            end
            ST: begin
                cyc(MEM_ADDR, rb());
                wait_phase(MEM_WRITE, wm, f);
                if (f) fault_hold();
            end
            RR: begin cyc(EXEC_R, rb()); cyc(ALU_WB, rb()); end
            II: begin cyc(EXEC_I, rb()); cyc(ALU_WB, rb()); end
            LU: begin cyc(EXEC_LUI, rb()); cyc(ALU_WB, rb()); end
            BR: cyc(BRANCH, rb());
            JA: cyc(JAL, rb());
            JR: cyc(JALR, rb());
            default: begin
`ifdef ILLEGAL_TRAP_EN
                repeat (3) cyc(TRAP, rb());
                do_reset();
`endif
            end
        endcase
    endtask

    function automatic logic [6:0] pick_op();
        logic [6:0] ops [8] = '{LD, ST, RR, II, LU, BR, JA, JR};
        logic [6:0] x;
        if ($urandom_range(0, 9) != 0) return ops[$urandom_range(0, 7)];
        do x = 7'($urandom); while (x inside {LD, ST, RR, II, LU, BR, JA, JR});
        return x;
    endfunction

    function automatic int pick_wait();
        int k = $urandom_range(0, 24);
        return k == 0 ? TO : k == 1 ? TO - 1 : k % 4;
    endfunction

    initial begin
        @(posedge clk);
        #1;
        do_reset();
        run_instr(RR, 0, 0);
        run_instr(LD, 0, 3);
        run_instr(JA, 0, 0);
        run_instr(ST, 2, 0);
        run_instr(BR, 0, 0);
        run_instr(JR, 1, 0);
        run_instr(LU, 0, 0);
        run_instr(II, 0, 0);
        run_instr(RR, TO - 1, 0);
        run_instr(ST, 0, TO - 1);
        run_instr(LD, 0, TO - 1);
        run_instr(RR, TO, 0);
        run_instr(LD, 0, TO);
        run_instr(ST, 0, TO);
        run_instr(7'b1111111, 0, 0);
        run_instr(RR, 0, 0);
        opcode = LD;
        cyc(FETCH, 1'b1);
        cyc(DECODE, 1'b0);
        cyc(MEM_ADDR, 1'b0);
        repeat (5) cyc(MEM_READ, 1'b0);
        do_reset();
        run_instr(LD, 0, 0);
        for (int i = 0; i < 200; i++) run_instr(pick_op(), pick_wait(), pick_wait());
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
